// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer, instruction memory and decode.
// The master modport is the sequencer side; slave is the memory/decode environment.
interface fetch_sequencer_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_steps;
  logic        jmp;
  logic [25:0] jmp_index;
  logic [31:0] redir_base;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic [31:0] fetch_count;

  modport master (
    input  stall, br_taken, br_steps, jmp, jmp_index, redir_base,
    input  imem_ack, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc, fetch_count
  );

  modport slave (
    output stall, br_taken, br_steps, jmp, jmp_index, redir_base,
    output imem_ack, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with branch/jump redirect.
// Every output is a register; the next-state process computes all of them.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_imem_req, w_imem_req_nxt;
  logic [31:0] r_imem_addr, w_imem_addr_nxt;
  logic        r_instr_valid, w_instr_valid_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_instr_pc, w_instr_pc_nxt;
  logic [31:0] r_fetch_count, w_fetch_count_nxt;

  logic        w_redirect;
  logic [31:0] w_jmp_target;
  logic [31:0] w_br_target;
  logic [31:0] w_target;

  // Jump wins when both redirects arrive together.
  assign w_redirect   = bus.jmp | bus.br_taken;
  assign w_jmp_target = {bus.redir_base[31:28], bus.jmp_index, 2'b00};
  assign w_br_target  = {bus.redir_base[31:2], 2'b00} + {bus.br_steps[29:0], 2'b00};
  assign w_target     = bus.jmp ? w_jmp_target : w_br_target;

  always_comb begin
    // NOTE: every next-value defaults to "hold" before the case, so no path
    // through the case can leave a signal unassigned and infer a latch.
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_imem_req_nxt    = r_imem_req;
    w_imem_addr_nxt   = r_imem_addr;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_fetch_count_nxt = r_fetch_count;

    unique case (r_state)
      IDLE: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else if (!bus.stall) begin
          w_state_nxt     = FETCH;
          w_imem_req_nxt  = 1'b1;
          w_imem_addr_nxt = r_pc;
        end
      end
      FETCH: begin
        if (bus.imem_ack && w_redirect) begin
          w_pc_nxt       = w_target;
          w_imem_req_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end else if (bus.imem_ack) begin
          w_instr_nxt       = bus.imem_rdata;
          w_instr_pc_nxt    = r_imem_addr;
          w_instr_valid_nxt = 1'b1;
          w_pc_nxt          = r_imem_addr + 32'd4;
          w_imem_req_nxt    = 1'b0;
          w_state_nxt       = HOLD;
        end else if (w_redirect) begin
          // Request stays on the bus; its response is dropped in DRAIN.
          w_pc_nxt    = w_target;
          w_state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (w_redirect) begin
          w_instr_valid_nxt = 1'b0;
          w_pc_nxt          = w_target;
          w_state_nxt       = IDLE;
        end else if (bus.instr_ready) begin
          w_instr_valid_nxt = 1'b0;
          w_fetch_count_nxt = r_fetch_count + 32'd1;
          w_state_nxt       = IDLE;
        end
      end
      DRAIN: begin
        if (w_redirect) w_pc_nxt = w_target;
        if (bus.imem_ack) begin
          w_imem_req_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_imem_req    <= w_imem_req_nxt;
      r_imem_addr   <= w_imem_addr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_imem_addr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.pc          = r_pc;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: expected request addresses and deliveries are queued as
// stimulus is set up and compared as the sequencer issues/delivers them.
module tb_fetch_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        force_ack = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] exp_addr[$];
  exp_t        exp_instr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.data = mem_word(a);
    exp_addr.push_back(a);
    exp_instr.push_back(e);
  endtask

  // One clock: memory responder and scoreboard monitor on the falling edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.imem_req && wait_cnt >= ack_delay) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = mem_word(bus.imem_addr);
      wait_cnt       = 0;
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hBAD0_BAD0;
      wait_cnt       = bus.imem_req ? wait_cnt + 1 : 0;
    end
    if (force_ack) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hFFFF_0000;
    end
    if (bus.imem_req && !prev_req && exp_addr.size() != 0)
      check("req_addr", bus.imem_addr, exp_addr.pop_front());
    if (bus.instr_valid && !prev_valid && exp_instr.size() != 0) begin
      e = exp_instr.pop_front();
      check("instr_pc", bus.instr_pc, e.pc);
      check("instr", bus.instr, e.data);
    end
    prev_req   = bus.imem_req;
    prev_valid = bus.instr_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while ((exp_addr.size() != 0 || exp_instr.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("sb_pending", exp_addr.size() + exp_instr.size(), 0);
    exp_addr.delete();
    exp_instr.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},    bus.pc, 32'h0);
    check({tag, "_req"},   bus.imem_req, 0);
    check({tag, "_addr"},  bus.imem_addr, 32'h0);
    check({tag, "_valid"}, bus.instr_valid, 0);
    check({tag, "_instr"}, bus.instr, 32'h0);
    check({tag, "_ipc"},   bus.instr_pc, 32'h0);
    check({tag, "_cnt"},   bus.fetch_count, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    bus.stall       = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_steps    = '0;
    bus.jmp         = 1'b0;
    bus.jmp_index   = '0;
    bus.redir_base  = '0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b1;

    // Reset, then three sequential zero-wait fetches with decode always ready.
    expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
    tick(); tick();
    check_reset_state("rst");
    reset = 1'b1;
    tick();
    check("first_req", bus.imem_req, 1);
    run_until_empty(40);
    check("cnt_after3", bus.fetch_count, 3);
    bus.stall = 1'b1;
    tick();
    check("pc_after3", bus.pc, 32'hC);

    // HOLD at instr_pc=8, hold without ready, then branch redirect.
    bus.jmp = 1'b1; bus.redir_base = 32'h0; bus.jmp_index = 26'h2;
    tick();
    bus.jmp = 1'b0;
    check("idle_redir_pc", bus.pc, 32'h8);
    expect_fetch(32'h8);
    bus.instr_ready = 1'b0;
    bus.stall = 1'b0;
    run_until_empty(20);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", bus.instr_valid, 1);
      check("hold_ipc", bus.instr_pc, 32'h8);
      check("hold_instr", bus.instr, mem_word(32'h8));
    end
    bus.br_taken = 1'b1; bus.redir_base = 32'd12; bus.br_steps = 32'd100;
    bus.instr_ready = 1'b1;
    tick();
    bus.br_taken = 1'b0;
    check("br_valid_drop", bus.instr_valid, 0);
    check("br_pc", bus.pc, 32'd412);
    check("br_cnt_same", bus.fetch_count, 3);
    expect_fetch(32'd412);
    bus.stall = 1'b0;
    run_until_empty(20);
    bus.stall = 1'b1;
    check("cnt_412", bus.fetch_count, 4);

    // Simultaneous jump and branch: jump target wins.
    bus.jmp = 1'b1; bus.br_taken = 1'b1;
    bus.redir_base = 32'hA000_0010; bus.jmp_index = 26'h40; bus.br_steps = 32'd7;
    tick();
    bus.jmp = 1'b0; bus.br_taken = 1'b0;
    check("jmp_wins_pc", bus.pc, 32'hA000_0100);
    expect_fetch(32'hA000_0100);
    bus.stall = 1'b0;
    run_until_empty(20);
    bus.stall = 1'b1;
    check("cnt_jmp", bus.fetch_count, 5);

    // Redirects during a 5-cycle ack delay: address held, data dropped, latest target wins.
    ack_delay = 5;
    exp_addr.push_back(32'hA000_0104);
    expect_fetch(32'h200);
    bus.stall = 1'b0;
    tick(); tick();
    bus.br_taken = 1'b1; bus.redir_base = 32'h100; bus.br_steps = -32'sd4;
    tick();
    bus.br_taken = 1'b0;
    check("drain_br_pc", bus.pc, 32'hF0);
    bus.jmp = 1'b1; bus.redir_base = 32'h0; bus.jmp_index = 26'h80;
    tick();
    bus.jmp = 1'b0;
    check("drain_jmp_pc", bus.pc, 32'h200);
    for (int n = 0; n < 20 && bus.imem_req; n++) begin
      check("drain_addr", bus.imem_addr, 32'hA000_0104);
      check("drain_valid", bus.instr_valid, 0);
      tick();
    end
    check("drain_end_req", bus.imem_req, 0);
    check("drain_end_valid", bus.instr_valid, 0);
    ack_delay = 0;
    run_until_empty(20);
    bus.stall = 1'b1;
    check("cnt_drain", bus.fetch_count, 6);

    // Ack and redirect in the same FETCH cycle: data discarded.
    exp_addr.push_back(32'h204);
    bus.stall = 1'b0;
    tick();
    bus.jmp = 1'b1; bus.redir_base = 32'h0; bus.jmp_index = 26'h100;
    bus.stall = 1'b1;
    tick();
    bus.jmp = 1'b0;
    check("ackredir_valid", bus.instr_valid, 0);
    check("ackredir_req", bus.imem_req, 0);
    check("ackredir_pc", bus.pc, 32'h400);
    tick();
    check("ackredir_valid2", bus.instr_valid, 0);

    // Stray acks in IDLE and HOLD are ignored.
    force_ack = 1'b1;
    tick(); tick();
    force_ack = 1'b0;
    check("idle_ack_valid", bus.instr_valid, 0);
    check("idle_ack_req", bus.imem_req, 0);
    check("idle_ack_pc", bus.pc, 32'h400);
    expect_fetch(32'h400);
    bus.instr_ready = 1'b0;
    bus.stall = 1'b0;
    run_until_empty(20);
    bus.stall = 1'b1;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("hold_ack_instr", bus.instr, mem_word(32'h400));
    check("hold_ack_valid", bus.instr_valid, 1);
    check("hold_ack_pc", bus.pc, 32'h404);
    bus.instr_ready = 1'b1;
    tick();
    check("hold_ack_cnt", bus.fetch_count, 7);

    // Stall in IDLE, release, and fetch at the top of memory (pc wraps).
    bus.jmp = 1'b1; bus.redir_base = 32'hF000_0000; bus.jmp_index = 26'h3FF_FFFF;
    tick();
    bus.jmp = 1'b0;
    check("top_pc", bus.pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_req", bus.imem_req, 0);
    end
    expect_fetch(32'hFFFF_FFFC);
    bus.stall = 1'b0;
    tick();
    check("unstall_req", bus.imem_req, 1);
    check("unstall_addr", bus.imem_addr, 32'hFFFF_FFFC);
    run_until_empty(20);
    bus.stall = 1'b1;
    check("wrap_pc", bus.pc, 32'h0);
    check("wrap_cnt", bus.fetch_count, 8);

    // Reset in the middle of DRAIN, then a late ack.
    ack_delay = 5;
    exp_addr.push_back(32'h0);
    bus.stall = 1'b0;
    tick(); tick();
    bus.br_taken = 1'b1; bus.redir_base = 32'h1000; bus.br_steps = 32'd0;
    tick();
    bus.br_taken = 1'b0;
    check("mid_drain_pc", bus.pc, 32'h1000);
    check("mid_drain_req", bus.imem_req, 1);
    reset = 1'b0;
    tick();
    check_reset_state("rst2");
    reset = 1'b1;
    bus.stall = 1'b1;
    ack_delay = 0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("late_ack_valid", bus.instr_valid, 0);
    check("late_ack_req", bus.imem_req, 0);
    check("late_ack_instr", bus.instr, 32'h0);
    expect_fetch(32'h0);
    bus.stall = 1'b0;
    run_until_empty(20);
    bus.stall = 1'b1;
    check("post_rst_cnt", bus.fetch_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
